arm_trace_buffer: RTL and testbench

Hardware trace capture for the single-cycle ARM core. It records one entry per retired instruction (PC, instruction, ALU result, flags, condition-execute bit) into a circular on-chip buffer. Capture supports three modes: continuous wrap, stop-when-full, and PC-trigger with post-trigger count. After capture stops, the buffer is drained oldest-first over a valid/ready stream, so an external host can reconstruct execution without simulator visibility.

---
 rtl/arm_trace_pkg.sv | 44 ++++
 rtl/arm_trace_buffer_ram.sv | 42 ++++
 rtl/arm_trace_buffer.sv | 241 ++++++++++++++++++++++++
 tb/tb_arm_trace_buffer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_trace_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arm_trace_pkg
//  Description : Shared types and encodings for the ARM trace capture buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package arm_trace_pkg;

  // Reported on the state port; the encoding is visible to the host.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_POST    = 2'd2,
    ST_DRAIN   = 2'd3
  } trace_state_t;

  // Capture policy selected on the mode port; MODE_WRAP_ALT behaves as MODE_WRAP.
  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_FULL     = 2'd1,
    MODE_TRIG     = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } trace_mode_t;

  localparam int c_TRACE_DATA_W = 32;
  localparam int c_FLAGS_W      = 4;

  // One trace entry at the default field width. The buffer stores entries as a
  // flat vector packed in exactly this field order (pc in the MSBs).
  typedef struct packed {
    logic [c_TRACE_DATA_W-1:0] pc;
    logic [c_TRACE_DATA_W-1:0] instr;
    logic [c_TRACE_DATA_W-1:0] result;
    logic [c_FLAGS_W-1:0]      flags;
    logic                      condex;
  } trace_rec_t;

  // Width of one packed entry for a given field width.
  function automatic int rec_width(input int data_w);
    return 3 * data_w + c_FLAGS_W + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_trace_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module      : trace_ram
//  Description : Simple dual-port RAM, one write port, one registered read
//                port (one-cycle latency). Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module trace_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 101,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write port: store the entry presented this cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: the output register only changes on a read, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/arm_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : arm_trace_buffer
//  Description : Circular trace capture of retired ARM instructions with wrap,
//                stop-when-full and PC-trigger modes, drained oldest-first
//                over a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module arm_trace_buffer
  import arm_trace_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [CNT_W-1:0]  post_count,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_pc,
  input  logic [DATA_W-1:0] cap_instr,
  input  logic [DATA_W-1:0] cap_result,
  input  logic [3:0]        cap_flags,
  input  logic              cap_condex,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              triggered,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_instr,
  output logic [DATA_W-1:0] rd_result,
  output logic [3:0]        rd_flags,
  output logic              rd_condex
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int REC_W  = rec_width(DATA_W);
  localparam logic [CNT_W-1:0]  c_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  c_CNT1   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] c_ADDR1  = ADDR_W'(1);

  trace_state_t      state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              triggered_q, triggered_d;
  logic [CNT_W-1:0]  remain_q, remain_d;        // post-trigger records still to capture
  logic [CNT_W-1:0]  issue_rem_q, issue_rem_d;  // entries not yet read from RAM
  logic [CNT_W-1:0]  deliver_rem_q, deliver_rem_d; // entries not yet accepted by host
  logic              ram_vld_q, ram_vld_d;      // RAM output register holds an unsent entry
  logic              rd_valid_q, rd_valid_d;
  logic [REC_W-1:0]  rd_rec_q, rd_rec_d;

  trace_mode_t       mode_e;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [REC_W-1:0]  ram_rd_data;
  logic [REC_W-1:0]  wr_rec;
  logic              go_drain;
  logic              handshake;
  logic              out_load;

  assign mode_e = trace_mode_t'(mode);
  assign wr_rec = {cap_pc, cap_instr, cap_result, cap_flags, cap_condex};

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_rec),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Next-state, pointer and readout pipeline control.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    overflow_d    = overflow_q;
    triggered_d   = triggered_q;
    remain_d      = remain_q;
    issue_rem_d   = issue_rem_q;
    deliver_rem_d = deliver_rem_q;
    ram_vld_d     = ram_vld_q;
    rd_valid_d    = rd_valid_q;
    rd_rec_d      = rd_rec_q;
    ram_wr_en     = 1'b0;
    ram_rd_en     = 1'b0;
    go_drain      = 1'b0;
    handshake     = 1'b0;
    out_load      = 1'b0;

    if (arm) begin
      // A new capture abandons whatever was in progress, including a readout.
      state_d       = ST_CAPTURE;
      wr_ptr_d      = '0;
      count_d       = '0;
      overflow_d    = 1'b0;
      triggered_d   = 1'b0;
      remain_d      = '0;
      issue_rem_d   = '0;
      deliver_rem_d = '0;
      ram_vld_d     = 1'b0;
      rd_valid_d    = 1'b0;
    end else begin
      case (state_q)
        ST_CAPTURE, ST_POST: begin
          if (cap_valid) begin
            ram_wr_en = 1'b1;
            wr_ptr_d  = wr_ptr_q + c_ADDR1;
            if (count_q == c_FULL) begin
              overflow_d = 1'b1;
            end else begin
              count_d = count_q + c_CNT1;
            end
            if (state_q == ST_POST) begin
              remain_d = remain_q - c_CNT1;
              if (remain_q == c_CNT1) begin
                go_drain = 1'b1;
              end
            end else begin
              if (mode_e == MODE_FULL && count_d == c_FULL) begin
                go_drain = 1'b1;
              end
              if (mode_e == MODE_TRIG && !triggered_q && cap_pc == trig_pc) begin
                triggered_d = 1'b1;
                remain_d    = post_count;
                if (post_count == '0) begin
                  go_drain = 1'b1;
                end else begin
                  state_d = ST_POST;
                end
              end
            end
          end
          // The record in the stop cycle has already been taken above.
          if (stop) begin
            go_drain = 1'b1;
          end
          if (go_drain) begin
            // After a wrap the oldest surviving entry sits at the write pointer.
            state_d       = ST_DRAIN;
            rd_ptr_d      = overflow_d ? wr_ptr_d : '0;
            issue_rem_d   = count_d;
            deliver_rem_d = count_d;
          end
        end

        ST_DRAIN: begin
          if (deliver_rem_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            handshake = rd_valid_q && rd_ready;
            // Move the fetched entry forward whenever the output slot is free or emptying.
            out_load  = ram_vld_q && (!rd_valid_q || rd_ready);
            ram_rd_en = (issue_rem_q != '0) && (!ram_vld_q || out_load);
            if (ram_rd_en) begin
              rd_ptr_d    = rd_ptr_q + c_ADDR1;
              issue_rem_d = issue_rem_q - c_CNT1;
              ram_vld_d   = 1'b1;
            end else if (out_load) begin
              ram_vld_d = 1'b0;
            end
            if (out_load) begin
              rd_valid_d = 1'b1;
              rd_rec_d   = ram_rd_data;
            end else if (handshake) begin
              rd_valid_d = 1'b0;
            end
            if (handshake) begin
              deliver_rem_d = deliver_rem_q - c_CNT1;
              if (deliver_rem_q == c_CNT1) begin
                state_d = ST_IDLE;
              end
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any capture or readout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      overflow_q    <= 1'b0;
      triggered_q   <= 1'b0;
      remain_q      <= '0;
      issue_rem_q   <= '0;
      deliver_rem_q <= '0;
      ram_vld_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_rec_q      <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      triggered_q   <= triggered_d;
      remain_q      <= remain_d;
      issue_rem_q   <= issue_rem_d;
      deliver_rem_q <= deliver_rem_d;
      ram_vld_q     <= ram_vld_d;
      rd_valid_q    <= rd_valid_d;
      rd_rec_q      <= rd_rec_d;
    end
  end

  assign state     = state_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;
  assign rd_valid  = rd_valid_q;
  assign rd_pc     = rd_rec_q[REC_W-1 -: DATA_W];
  assign rd_instr  = rd_rec_q[2*DATA_W+4 -: DATA_W];
  assign rd_result = rd_rec_q[DATA_W+4 -: DATA_W];
  assign rd_flags  = rd_rec_q[4:1];
  assign rd_condex = rd_rec_q[0];

endmodule
`default_nettype wire

// File: tb/tb_arm_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arm_trace_buffer
//  Description : Self-checking bench for arm_trace_buffer (DEPTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arm_trace_buffer;
  import arm_trace_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              arm, stop;
  logic [1:0]        mode;
  logic [DATA_W-1:0] trig_pc;
  logic [CNT_W-1:0]  post_count;
  logic              cap_valid;
  logic [DATA_W-1:0] cap_pc, cap_instr, cap_result;
  logic [3:0]        cap_flags;
  logic              cap_condex;
  logic [1:0]        state;
  logic [CNT_W-1:0]  count;
  logic              overflow, triggered, rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_pc, rd_instr, rd_result;
  logic [3:0]        rd_flags;
  logic              rd_condex;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int drain_cyc;
  int first_valid_cyc;
  logic [1:0] prev_state;
  logic       prev_valid;

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] trig;
    logic [3:0]  post;
    int          nrec;
    bit          do_stop;
    int          exp_count;
    bit          exp_ovf;
    bit          exp_trg;
    logic [31:0] first_pc;
    int          rmode;     // 0: ready always, 1: random ready, 2: 1-0-0-1 pattern
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  arm_trace_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .arm(arm), .stop(stop), .mode(mode),
    .trig_pc(trig_pc), .post_count(post_count),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_instr(cap_instr),
    .cap_result(cap_result), .cap_flags(cap_flags), .cap_condex(cap_condex),
    .state(state), .count(count), .overflow(overflow), .triggered(triggered),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_result(rd_result),
    .rd_flags(rd_flags), .rd_condex(rd_condex)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic trace_rec_t model_rec(input logic [31:0] pc);
    trace_rec_t r;
    r.pc     = pc;
    r.instr  = 32'hE280_0000 | pc;
    r.result = pc * 3 + 32'h100;
    r.flags  = pc[5:2];
    r.condex = pc[2] ^ pc[3];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (state == 2'd3 && prev_state != 2'd3) drain_cyc = cyc;
    if (rd_valid && !prev_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    prev_state = state;
    prev_valid = rd_valid;
  endtask

  task automatic drive_rec(input logic [31:0] pc);
    trace_rec_t r;
    r          = model_rec(pc);
    cap_valid  = 1'b1;
    cap_pc     = r.pc;
    cap_instr  = r.instr;
    cap_result = r.result;
    cap_flags  = r.flags;
    cap_condex = r.condex;
  endtask

  task automatic arm_pulse(input logic [1:0] m, input logic [31:0] tp, input logic [3:0] pc_cnt);
    mode            = m;
    trig_pc         = tp;
    post_count      = pc_cnt;
    arm             = 1'b1;
    drain_cyc       = -1;
    first_valid_cyc = -1;
    step();
    arm = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      drive_rec(32'(4 * k));
      step();
    end
    cap_valid = 1'b0;
  endtask

  // Consume the readout with the chosen ready pattern, checking every presented entry.
  task automatic drain_check(input logic [31:0] exp_q[$], input int rmode);
    int idx = 0;
    int pat = 0;
    int n;
    logic r, hs;
    trace_rec_t e;
    n = exp_q.size();
    for (int t = 0; t < 200 && idx < n; t++) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = ((pat % 4) == 0) || ((pat % 4) == 3);
      endcase
      pat++;
      rd_ready = r;
      hs = rd_valid && r;
      if (rd_valid) begin
        e = model_rec(exp_q[idx]);
        check($sformatf("rd_pc[%0d]", idx), rd_pc, e.pc);
        check($sformatf("rd_instr[%0d]", idx), rd_instr, e.instr);
        check($sformatf("rd_result[%0d]", idx), rd_result, e.result);
        check($sformatf("rd_flags_condex[%0d]", idx), {rd_flags, rd_condex}, {e.flags, e.condex});
        if (r) idx++;
      end
      step();
      if (hs && rmode == 0 && idx < n) check("back_to_back", rd_valid, 1);
    end
    rd_ready = 1'b0;
    check("entries_delivered", idx, n);
    check("rd_valid_dropped", rd_valid, 0);
    check("idle_after_drain", state, 0);
    check("first_valid_latency", first_valid_cyc - drain_cyc, 2);
  endtask

  initial begin
    logic [31:0] q[$];
    bit saw;

    vecs[0] = '{2'd1, 32'h0,  4'd0, 10, 1'b0, 8, 1'b0, 1'b0, 32'h00, 0};
    vecs[1] = '{2'd0, 32'h0,  4'd0, 11, 1'b1, 8, 1'b1, 1'b0, 32'h0C, 1};
    vecs[2] = '{2'd2, 32'h10, 4'd2, 16, 1'b0, 7, 1'b0, 1'b1, 32'h00, 2};
    vecs[3] = '{2'd3, 32'h0,  4'd0, 5,  1'b1, 5, 1'b0, 1'b0, 32'h00, 0};
    vecs[4] = '{2'd2, 32'h08, 4'd0, 6,  1'b0, 3, 1'b0, 1'b1, 32'h00, 2};
    vecs[5] = '{2'd2, 32'h40, 4'd3, 12, 1'b1, 8, 1'b1, 1'b0, 32'h10, 1};
    vecs[6] = '{2'd2, 32'h28, 4'd2, 14, 1'b0, 8, 1'b1, 1'b1, 32'h14, 0};

    rst = 1'b0; arm = 1'b0; stop = 1'b0; mode = 2'd0; trig_pc = '0; post_count = '0;
    cap_valid = 1'b0; cap_pc = '0; cap_instr = '0; cap_result = '0; cap_flags = '0;
    cap_condex = 1'b0; rd_ready = 1'b0;
    prev_state = 2'd0; prev_valid = 1'b0; drain_cyc = -1; first_valid_cyc = -1;
    step(); step();
    check("reset_state", state, 0);
    check("reset_count", count, 0);
    check("reset_overflow", overflow, 0);
    check("reset_rd_valid", rd_valid, 0);
    rst = 1'b1;
    step();

    // Table-driven capture/readout vectors.
    for (int v = 0; v < 7; v++) begin
      arm_pulse(vecs[v].mode, vecs[v].trig, vecs[v].post);
      check($sformatf("v%0d_capture", v), state, 1);
      feed(vecs[v].nrec);
      if (vecs[v].do_stop) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
      end
      for (int t = 0; t < 20 && state != 2'd3; t++) step();
      check($sformatf("v%0d_in_drain", v), state, 3);
      check($sformatf("v%0d_count", v), count, vecs[v].exp_count);
      check($sformatf("v%0d_overflow", v), overflow, vecs[v].exp_ovf);
      check($sformatf("v%0d_triggered", v), triggered, vecs[v].exp_trg);
      q.delete();
      for (int i = 0; i < vecs[v].exp_count; i++) q.push_back(vecs[v].first_pc + 32'(4 * i));
      drain_check(q, vecs[v].rmode);
    end

    // Reset while in POST takes effect without a clock edge.
    arm_pulse(2'd2, 32'h08, 4'd5);
    feed(4);
    check("post_state", state, 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_count", count, 0);
    check("async_rst_triggered", triggered, 0);
    check("async_rst_rd_pc", rd_pc, 0);
    check("async_rst_rd_instr", rd_instr, 0);
    step(); step();
    rst = 1'b1;
    step();

    // Arm then stop with nothing captured: straight back to IDLE.
    arm_pulse(2'd0, 32'h0, 4'd0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("empty_drain_state", state, 3);
    saw = prev_valid;
    step();
    check("empty_idle_next", state, 0);
    for (int t = 0; t < 5; t++) begin
      if (rd_valid) saw = 1'b1;
      step();
    end
    check("empty_no_rd_valid", saw, 0);
    check("empty_count", count, 0);

    // Record presented with stop is the last entry read.
    arm_pulse(2'd0, 32'h0, 4'd0);
    feed(3);
    drive_rec(32'h40);
    stop = 1'b1;
    step();
    stop = 1'b0;
    cap_valid = 1'b0;
    check("stop_cap_state", state, 3);
    check("stop_cap_count", count, 4);
    q.delete();
    q.push_back(32'h00); q.push_back(32'h04); q.push_back(32'h08); q.push_back(32'h40);
    drain_check(q, 0);

    // Arm in the middle of a readout.
    arm_pulse(2'd0, 32'h0, 4'd0);
    feed(4);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int t = 0; t < 10 && !rd_valid; t++) step();
    check("mid_drain_valid", rd_valid, 1);
    arm_pulse(2'd0, 32'h0, 4'd0);
    check("rearm_rd_valid", rd_valid, 0);
    check("rearm_count", count, 0);
    check("rearm_state", state, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    step();
    check("rearm_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
